// File: rtl/parking_occupancy_arbiter.sv
// parking_occupancy_arbiter
// -------------------------
// Shares one BCD occupancy counter between two gate lanes (A and B). Each
// lane's sensor FSM produces one-cycle incr/decr pulses; these are queued in
// four small pending counters and serialised into at most one tick/sign per
// cycle towards the counter. The block also mirrors the committed occupancy,
// enforces the lot capacity and drives full/empty and gate-lock status.
//
// Configuration macro: PARKING_NET_CANCEL_EN
//   defined   : an increment and a decrement that are both grantable in the
//               same cycle are consumed together without a tick.
//   undefined : the decrement is granted first; the increment stays pending.
//
// Handshake: the block has no back-pressure. Each input pulse is a one-cycle
// event request that is always accepted (or dropped on saturation, flagged
// by drop_err). tick is a one-cycle strobe with sign valid in the same cycle;
// the downstream counter must accept it in that cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   incr_a, decr_a      lane A entry/exit pulses
//   incr_b, decr_b      lane B entry/exit pulses
//   tick, sign          step strobe and direction (1 = decrement)
//   occupancy           committed vehicle count
//   full, empty         occupancy == CAPACITY / occupancy == 0
//   gate_lock_a/_b      lane entry must be refused
//   reject              one-cycle pulse: a queued decrement was discarded
//   drop_err            sticky: a pending counter overflowed
//   state_dbg_o         current arbiter FSM state (IDLE=0, SERVE=1, BLOCKED=2)

module parking_occupancy_arbiter #(
    parameter int CAPACITY = 9,
    parameter int CNT_W    = 4,
    parameter int PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incr_a,
    input  logic             decr_a,
    input  logic             incr_b,
    input  logic             decr_b,
    output logic             tick,
    output logic             sign,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             gate_lock_a,
    output logic             gate_lock_b,
    output logic             reject,
    output logic             drop_err,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

`ifdef PARKING_NET_CANCEL_EN
    localparam bit NET_CANCEL = 1'b1;
`else
    localparam bit NET_CANCEL = 1'b0;
`endif

    localparam int LW = CNT_W + 2;  // wide enough for occupancy + two pending counts

    // Pending counter slots: 0 = incr_a, 1 = decr_a, 2 = incr_b, 3 = decr_b
    localparam int IA = 0;
    localparam int DA = 1;
    localparam int IB = 2;
    localparam int DB = 3;

    state_t            state_q, state_d;
    logic [3:0][2:0]   pend_q, pend_d;
    logic              rr_inc_q, rr_inc_d;   // 0 = lane A next, 1 = lane B next
    logic              rr_dec_q, rr_dec_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              tick_q, tick_d;
    logic              sign_q, sign_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              lock_q, lock_d;
    logic              reject_q, reject_d;
    logic              drop_q, drop_d;

    logic [3:0]        pulse;
    logic [3:0]        grant;
    logic              inc_any, dec_any;
    logic              at_full, at_empty;
    logic              inc_ok, dec_ok;
    logic              inc_lane, dec_lane;   // 1 = lane B
    logic              any_d, dec_pend_d;
    logic [LW-1:0]     lock_sum;

    // Returns 1 when lane B wins. A lone requester wins regardless of ptr.
    function automatic logic pick_b(input logic req_a, input logic req_b, input logic ptr);
        if (req_a && req_b) begin
            return ptr;
        end
        return req_b;
    endfunction

    assign pulse = {decr_b, incr_b, decr_a, incr_a};

    // Arbitration on registered pending state
    always_comb begin
        grant    = 4'b0000;
        tick_d   = 1'b0;
        sign_d   = 1'b0;
        reject_d = 1'b0;
        occ_d    = occ_q;
        rr_inc_d = rr_inc_q;
        rr_dec_d = rr_dec_q;

        inc_any  = (pend_q[IA] != 3'd0) || (pend_q[IB] != 3'd0);
        dec_any  = (pend_q[DA] != 3'd0) || (pend_q[DB] != 3'd0);
        at_full  = (occ_q == CNT_W'(CAPACITY));
        at_empty = (occ_q == '0);
        inc_ok   = inc_any && !at_full;
        dec_ok   = dec_any && !at_empty;
        inc_lane = pick_b(pend_q[IA] != 3'd0, pend_q[IB] != 3'd0, rr_inc_q);
        dec_lane = pick_b(pend_q[DA] != 3'd0, pend_q[DB] != 3'd0, rr_dec_q);

        if (NET_CANCEL && inc_ok && dec_ok) begin
            // Entry and exit cancel out: consume both, occupancy unchanged
            grant[inc_lane ? IB : IA] = 1'b1;
            grant[dec_lane ? DB : DA] = 1'b1;
            rr_inc_d = ~rr_inc_q;
            rr_dec_d = ~rr_dec_q;
        end else if (dec_any) begin
            grant[dec_lane ? DB : DA] = 1'b1;
            rr_dec_d = ~rr_dec_q;
            if (at_empty) begin
                // Exit with nobody inside: discard instead of wrapping
                reject_d = 1'b1;
            end else begin
                tick_d = 1'b1;
                sign_d = 1'b1;
                occ_d  = occ_q - CNT_W'(1);
            end
        end else if (inc_ok) begin
            grant[inc_lane ? IB : IA] = 1'b1;
            rr_inc_d = ~rr_inc_q;
            tick_d   = 1'b1;
            occ_d    = occ_q + CNT_W'(1);
        end
        // Increments pending while full simply stay queued.
    end

    // Pending counters: capture pulses, retire grants, saturate at PEND_MAX
    always_comb begin
        pend_d = pend_q;
        drop_d = drop_q;
        for (int i = 0; i < 4; i++) begin
            if (pulse[i] && !grant[i]) begin
                if (pend_q[i] == 3'(PEND_MAX)) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 3'd1;
                end
            end else if (!pulse[i] && grant[i]) begin
                pend_d[i] = pend_q[i] - 3'd1;
            end
        end
    end

    // Status derived from next-state values so it lines up with occupancy
    always_comb begin
        full_d   = (occ_d == CNT_W'(CAPACITY));
        empty_d  = (occ_d == '0);
        lock_sum = LW'(occ_d) + LW'(pend_d[IA]) + LW'(pend_d[IB]);
        lock_d   = (lock_sum >= LW'(CAPACITY));
    end

    // FSM next state
    always_comb begin
        state_d    = state_q;
        any_d      = (pend_d != '0);
        dec_pend_d = (pend_d[DA] != 3'd0) || (pend_d[DB] != 3'd0);
        case (state_q)
            ST_IDLE: begin
                if (any_d) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!any_d) begin
                    state_d = ST_IDLE;
                end else if (!dec_pend_d && full_d) begin
                    state_d = ST_BLOCKED;
                end
            end
            ST_BLOCKED: begin
                if (dec_pend_d) begin
                    state_d = ST_SERVE;
                end else if (!any_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            rr_inc_q <= 1'b0;
            rr_dec_q <= 1'b0;
            occ_q    <= '0;
            tick_q   <= 1'b0;
            sign_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            lock_q   <= 1'b0;
            reject_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rr_inc_q <= rr_inc_d;
            rr_dec_q <= rr_dec_d;
            occ_q    <= occ_d;
            tick_q   <= tick_d;
            sign_q   <= sign_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            lock_q   <= lock_d;
            reject_q <= reject_d;
            drop_q   <= drop_d;
        end
    end

    assign tick        = tick_q;
    assign sign        = sign_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign gate_lock_a = lock_q;
    assign gate_lock_b = lock_q;
    assign reject      = reject_q;
    assign drop_err    = drop_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_parking_occupancy_arbiter.sv
// Directed bench for parking_occupancy_arbiter. Expected tick events
// {sign, occupancy-after} are queued when stimulus is driven and popped by a
// monitor whenever tick is seen.

module tb_parking_occupancy_arbiter;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             incr_a, decr_a, incr_b, decr_b;
    logic             tick, sign;
    logic [CNT_W-1:0] occupancy;
    logic             full, empty, gate_lock_a, gate_lock_b, reject, drop_err;
    logic [1:0]       state_dbg_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W:0] exp_q[$];

    parking_occupancy_arbiter #(.CAPACITY(9), .CNT_W(CNT_W), .PEND_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .incr_a(incr_a), .decr_a(decr_a), .incr_b(incr_b), .decr_b(decr_b),
        .tick(tick), .sign(sign), .occupancy(occupancy),
        .full(full), .empty(empty),
        .gate_lock_a(gate_lock_a), .gate_lock_b(gate_lock_b),
        .reject(reject), .drop_err(drop_err), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mask = {decr_b, incr_b, decr_a, incr_a}, held for n consecutive cycles
    task automatic pulse_train(input logic [3:0] mask, input int n);
        @(posedge clk); #1;
        {decr_b, incr_b, decr_a, incr_a} = mask;
        repeat (n) @(posedge clk);
        #1;
        {decr_b, incr_b, decr_a, incr_a} = 4'b0000;
    endtask

    task automatic pulse(input logic [3:0] mask);
        pulse_train(mask, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input int occ);
        exp_q.push_back({s, CNT_W'(occ)});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b0 && tick === 1'b1) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_tick: observed sign=%0b occ=%0d expected no tick", sign, occupancy);
            end
            if (exp_q.size() != 0) begin
                check("tick_event", {27'd0, sign, occupancy}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        {decr_b, incr_b, decr_a, incr_a} = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_tick", tick, 0);
        check("rst_sign", sign, 0);
        check("rst_occ", occupancy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_lock_a", gate_lock_a, 0);
        check("rst_lock_b", gate_lock_b, 0);
        check("rst_reject", reject, 0);
        check("rst_drop", drop_err, 0);
        check("rst_state", state_dbg_o, 0);
        rst = 1'b0;

        // Single entry: tick two cycles after the pulse
        push(1'b0, 1);
        pulse(4'b0001);
        @(negedge clk);
        check("a_lat_early", tick, 0);
        @(negedge clk);
        check("a_tick", tick, 1);
        check("a_sign", sign, 0);
        check("a_occ", occupancy, 1);
        check("a_empty", empty, 0);
        @(negedge clk);
        check("a_one_shot", tick, 0);
        idle(2);

        // Back to zero, then simultaneous entries on both lanes
        push(1'b1, 0);
        pulse(4'b0010);
        idle(4);
        check("b_occ0", occupancy, 0);
        check("b_empty", empty, 1);
        push(1'b0, 1);
        push(1'b0, 2);
        pulse(4'b0101);
        @(negedge clk);
        check("b_lat_early", tick, 0);
        @(negedge clk);
        check("b_tick1", tick, 1);
        check("b_occ1", occupancy, 1);
        @(negedge clk);
        check("b_tick2", tick, 1);
        check("b_occ2", occupancy, 2);
        idle(3);

        // Fill to capacity
        for (int i = 3; i <= 9; i++) begin
            push(1'b0, i);
            pulse((i % 2) ? 4'b0001 : 4'b0100);
        end
        idle(4);
        check("c_occ9", occupancy, 9);
        check("c_full", full, 1);
        check("c_lock_a", gate_lock_a, 1);
        check("c_lock_b", gate_lock_b, 1);

        // Two entries while full: queued, no tick, no reject
        pulse_train(4'b0001, 2);
        idle(5);
        check("c_blk_occ", occupancy, 9);
        check("c_blk_state", state_dbg_o, 2);
        check("c_blk_reject", reject, 0);

        // One exit frees a slot: decrement then one queued increment
        push(1'b1, 8);
        push(1'b0, 9);
        pulse(4'b1000);
        idle(6);
        check("c_after_occ", occupancy, 9);
        check("c_after_full", full, 1);
        check("c_after_state", state_dbg_o, 2);

        // Five entries while blocked: pending saturates at 3
        pulse_train(4'b0001, 5);
        idle(3);
        check("e_drop", drop_err, 1);
        check("e_occ", occupancy, 9);
        // Exactly three queued entries remain: each exit releases one
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 8);
            push(1'b0, 9);
            pulse(4'b0010);
            idle(5);
        end
        push(1'b1, 8);
        pulse(4'b0010);
        idle(5);
        check("e_drain_occ", occupancy, 8);
        check("e_drain_state", state_dbg_o, 0);
        check("e_drain_full", full, 0);
        check("e_drain_lock", gate_lock_a, 0);
        check("e_drop_sticky", drop_err, 1);

        // Reset clears the sticky error
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("d_rst_drop", drop_err, 0);
        check("d_rst_occ", occupancy, 0);
        rst = 1'b0;

        // Exit at zero: rejected, no tick
        pulse(4'b0010);
        @(negedge clk);
        check("d_reject_early", reject, 0);
        @(negedge clk);
        check("d_reject", reject, 1);
        check("d_tick", tick, 0);
        check("d_occ", occupancy, 0);
        @(negedge clk);
        check("d_reject_one_shot", reject, 0);
        idle(2);

        // Simultaneous entry (A) and exit (B) at occupancy 4
        for (int i = 1; i <= 4; i++) begin
            push(1'b0, i);
            pulse((i % 2) ? 4'b0001 : 4'b0100);
        end
        idle(4);
        check("f_occ4", occupancy, 4);
`ifndef PARKING_NET_CANCEL_EN
        push(1'b1, 3);
        push(1'b0, 4);
`endif
        pulse(4'b1001);
        idle(6);
        check("f_occ_final", occupancy, 4);
        check("f_state", state_dbg_o, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
